// File: rtl/bram_2048x8_dp.sv
// ============================================================================
// Module   : bram_2048x8_dp
// Purpose  : True dual-port 2048x8 synchronous RAM with per-bit write masks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_2048x8_dp #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              CE0,
   input  logic [ADDR_W-1:0] A0,
   input  logic [DATA_W-1:0] D0,
   input  logic              WE0,
   input  logic [DATA_W-1:0] WEM0,
   output logic [DATA_W-1:0] Q0,
   input  logic              CE1,
   input  logic [ADDR_W-1:0] A1,
   input  logic [DATA_W-1:0] D1,
   input  logic              WE1,
   input  logic [DATA_W-1:0] WEM1,
   output logic [DATA_W-1:0] Q1
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_array [0:DEPTH-1] = '{default: '0};

   logic              wr0_en;
   logic              wr1_en;
   logic [DATA_W-1:0] q0_d, q0_q;
   logic [DATA_W-1:0] q1_d, q1_q;

   always_comb begin
      wr0_en = CE0 & WE0;
      wr1_en = CE1 & WE1;
      q0_d   = q0_q;
      q1_d   = q1_q;
      // Reads sample the array before this edge's writes land: read-first.
      if (CE0) q0_d = mem_array[A0];
      if (CE1) q1_d = mem_array[A1];
   end

   // Port 1 bit writes are issued after port 0, so port 1 wins overlapping bits.
   always_ff @(posedge CLK) begin
      if (RSTN) begin
         for (int i = 0; i < DATA_W; i++) begin
            if (wr0_en && WEM0[i]) mem_array[A0][i] <= D0[i];
         end
         for (int i = 0; i < DATA_W; i++) begin
            if (wr1_en && WEM1[i]) mem_array[A1][i] <= D1[i];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         q0_q <= '0;
         q1_q <= '0;
      end else begin
         q0_q <= q0_d;
         q1_q <= q1_d;
      end
   end

   assign Q0 = q0_q;
   assign Q1 = q1_q;

   always @(posedge CLK) begin
      if (CE0 && CE1 && (WE0 || WE1) && (A0 == A1))
         $info("bram_2048x8_dp: address conflict at 0x%0h", A0);
   end

endmodule

`default_nettype wire

// File: tb/tb_bram_2048x8_dp.sv
// ============================================================================
// Module   : tb_bram_2048x8_dp
// Purpose  : Directed plus randomized checks of bram_2048x8_dp against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_2048x8_dp;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ce0, we0, ce1, we1;
   logic [10:0] a0, a1;
   logic [7:0]  d0, wem0, d1, wem1;
   logic [7:0]  q0, q1;

   int checks   = 0;
   int failures = 0;

   logic [7:0] ref_mem [0:2047];
   logic [7:0] ref_q0, ref_q1;

   always #5 clk = ~clk;

   bram_2048x8_dp dut (
      .CLK (clk),  .RSTN (rstn),
      .CE0 (ce0),  .A0 (a0), .D0 (d0), .WE0 (we0), .WEM0 (wem0), .Q0 (q0),
      .CE1 (ce1),  .A1 (a1), .D1 (d1), .WE1 (we1), .WEM1 (wem1), .Q1 (q1)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // One clock edge: update the reference from the inputs present at the edge,
   // then compare both outputs shortly after the edge.
   task automatic cyc();
      logic [7:0] old0, old1;
      @(posedge clk);
      if (!rstn) begin
         ref_q0 = 8'h00;
         ref_q1 = 8'h00;
      end else begin
         old0 = ref_mem[a0];
         old1 = ref_mem[a1];
         if (ce0) ref_q0 = old0;
         if (ce1) ref_q1 = old1;
         if (ce0 && we0) ref_mem[a0] = (ref_mem[a0] & ~wem0) | (d0 & wem0);
         if (ce1 && we1) ref_mem[a1] = (ref_mem[a1] & ~wem1) | (d1 & wem1);
      end
      #1;
      check("q0_model", q0, ref_q0);
      check("q1_model", q1, ref_q1);
   endtask

   task automatic idle();
      ce0 = 0; we0 = 0; ce1 = 0; we1 = 0;
      a0 = '0; a1 = '0; d0 = '0; d1 = '0; wem0 = '0; wem1 = '0;
   endtask

   function automatic logic [10:0] rand_addr();
      if ($urandom_range(0, 1) == 0) return 11'($urandom_range(0, 15));
      return 11'(2047 - $urandom_range(0, 15));
   endfunction

   function automatic logic [7:0] rand_mask();
      case ($urandom_range(0, 3))
         0:       return 8'h00;
         1:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
      ref_q0 = 8'h00;
      ref_q1 = 8'h00;
      idle();
      rstn = 0;

      // Reset state
      cyc();
      check("reset_q0", q0, 8'h00);
      check("reset_q1", q1, 8'h00);
      rstn = 1;
      cyc();
      check("idle_q1", q1, 8'h00);

      // Read of zero-initialised array
      ce1 = 1; a1 = 11'h000;
      cyc();
      check("init_read", q1, 8'h00);

      // Full write then cross-port read, then hold
      idle(); ce0 = 1; we0 = 1; a0 = 11'h005; d0 = 8'hA5; wem0 = 8'hFF;
      cyc();
      idle(); ce1 = 1; a1 = 11'h005;
      cyc();
      check("read_a5", q1, 8'hA5);
      idle();
      cyc(); cyc();
      check("hold_a5", q1, 8'hA5);

      // Masked write
      ce0 = 1; we0 = 1; a0 = 11'h005; d0 = 8'h3C; wem0 = 8'h0F;
      cyc();
      idle(); ce1 = 1; a1 = 11'h005;
      cyc();
      check("masked", q1, 8'hAC);

      // Same-port read-during-write returns old word
      idle(); ce0 = 1; we0 = 1; a0 = 11'h7FF; d0 = 8'hAC; wem0 = 8'hFF;
      cyc();
      d0 = 8'h11;
      cyc();
      check("rfirst_old", q0, 8'hAC);
      we0 = 0;
      cyc();
      check("rfirst_new", q0, 8'h11);

      // Cross-port collision with merged masks
      idle(); ce0 = 1; we0 = 1; a0 = 11'h100; d0 = 8'h5A; wem0 = 8'hFF;
      cyc();
      ce1 = 1; we1 = 1; a1 = 11'h100; d1 = 8'h0F; wem1 = 8'h3C; d0 = 8'hF0;
      cyc();
      check("coll_q0_old", q0, 8'h5A);
      check("coll_q1_old", q1, 8'h5A);
      idle(); ce1 = 1; a1 = 11'h100;
      cyc();
      check("coll_merged", q1, 8'hCC);

      // Reset mid-operation drops the write
      idle(); ce1 = 1; a1 = 11'h005;
      cyc();
      check("pre_reset", q1, 8'hAC);
      rstn = 0; ce0 = 1; we0 = 1; a0 = 11'h005; d0 = 8'hFF; wem0 = 8'hFF;
      cyc();
      check("rst_q1", q1, 8'h00);
      check("rst_q0", q0, 8'h00);
      rstn = 1; idle(); ce1 = 1; a1 = 11'h005;
      cyc();
      check("rst_dropped", q1, 8'hAC);

      // Randomized traffic concentrated on a few addresses at both ends
      for (int n = 0; n < 3000; n++) begin
         rstn = ($urandom_range(0, 99) != 0);
         ce0  = $urandom_range(0, 3) != 0;
         ce1  = $urandom_range(0, 3) != 0;
         we0  = $urandom_range(0, 1) != 0;
         we1  = $urandom_range(0, 1) != 0;
         a0   = rand_addr();
         a1   = ($urandom_range(0, 3) == 0) ? a0 : rand_addr();
         d0   = 8'($urandom);
         d1   = 8'($urandom);
         wem0 = rand_mask();
         wem1 = rand_mask();
         cyc();
      end

      // Sweep the touched region back through both ports
      rstn = 1; idle();
      for (int i = 0; i < 16; i++) begin
         ce0 = 1; a0 = 11'(i);
         ce1 = 1; a1 = 11'(2047 - i);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
